// File: rtl/rc4_pkg.sv
// Shared RC4 S-RAM dimensions and requester identities.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rc4_pkg;

    localparam int S_ADDR_W  = 8;
    localparam int S_DATA_W  = 8;
    localparam int S_DEPTH   = 256;

    // Requester slots on the S-RAM arbiter, in port index order.
    typedef enum logic [1:0] {
        REQ_INIT = 2'd0,
        REQ_KSA  = 2'd1,
        REQ_PRGA = 2'd2
    } req_id_e;

    localparam int NUM_S_REQ = 3;

endpackage

// File: rtl/s_ram_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning from ptr upward, modulo N.
// Latency: purely combinational.
// Backpressure: none; a request that is not picked simply stays unserved this cycle.
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         vld
);

    logic [W:0] cand;

    // Walk the N candidates starting at ptr and latch the first requesting one.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand >= (W+1)'(N)) begin
                cand = cand - (W+1)'(N);
            end
            if (!vld && req[cand[W-1:0]]) begin
                vld = 1'b1;
                idx = cand[W-1:0];
            end
        end
        if (vld) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/s_ram_arbiter.sv
// Shares the single-port S-RAM between the RC4 engines, round-robin with an ownership lock.
// Latency: grant and RAM drive same cycle as req; read data and rvalid one cycle later.
// Backpressure: a non-granted requester stalls (holds req and its operands) indefinitely.
module s_ram_arbiter
    import rc4_pkg::*;
#(
    parameter int NUM_REQ = NUM_S_REQ,
    parameter int ADDR_W  = S_ADDR_W,
    parameter int DATA_W  = S_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_wren,
    output logic [DATA_W-1:0]         ram_data,
    input  logic [DATA_W-1:0]         ram_q
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr;
    logic               owner_vld;
    logic [PTR_W-1:0]   owner_idx;
    logic [NUM_REQ-1:0] rd_pend;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;

    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_idx;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] i);
        return (i == PTR_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Owner short-circuits round-robin; reset suppresses any access; winner drives the RAM port.
    always_comb begin
        gnt      = '0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        if (rst_n) begin
            if (owner_vld) begin
                gnt_vld        = req[owner_idx];
                gnt_idx        = owner_idx;
                gnt[owner_idx] = req[owner_idx];
            end else begin
                gnt_vld = pick_vld;
                gnt_idx = pick_idx;
                gnt     = pick_gnt;
            end
        end
        if (gnt_vld) begin
            ram_addr = addr_a[gnt_idx];
            ram_data = wdata_a[gnt_idx];
            ram_wren = we[gnt_idx];
        end
    end

    // Track the read in flight plus lock ownership and the round-robin start point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner_vld <= 1'b0;
            owner_idx <= '0;
            rd_pend   <= '0;
        end else begin
            rd_pend <= (gnt_vld && !we[gnt_idx]) ? gnt : '0;
            if (owner_vld) begin
                // Release happens on lock falling, whether or not the owner accessed this cycle.
                if (!lock[owner_idx]) begin
                    owner_vld <= 1'b0;
                    ptr       <= ptr_inc(owner_idx);
                end
            end else if (gnt_vld) begin
                if (lock[gnt_idx]) begin
                    owner_vld <= 1'b1;
                    owner_idx <= gnt_idx;
                end else begin
                    ptr <= ptr_inc(gnt_idx);
                end
            end
        end
    end

    assign rvalid = rd_pend;
    assign rdata  = ram_q;

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Self-checking bench for s_ram_arbiter with a behavioural single-port RAM attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_s_ram_arbiter;
    import rc4_pkg::*;

    localparam int N = NUM_S_REQ;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, lock, we;
    logic [23:0] addr, wdata;
    logic [2:0]  gnt, rvalid;
    logic [7:0]  rdata, ram_addr, ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q = 8'h00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    s_ram_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_wren (ram_wren),
        .ram_data (ram_data),
        .ram_q    (ram_q)
    );

    // Single-port RAM, read-during-write returns the new data, q one cycle after address.
    logic [7:0] mem [S_DEPTH];
    initial begin
        for (int i = 0; i < S_DEPTH; i++) mem[i] = 8'(i ^ 8'h5A);
        forever begin
            @(posedge clk);
            if (ram_wren) begin
                mem[ram_addr] = ram_data;
                ram_q         = ram_data;
            end else begin
                ram_q = mem[ram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                         input logic [2:0] w, input logic [23:0] a, input logic [23:0] d);
        rst_n = r;
        req   = rq;
        lock  = lk;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    // Directed vectors: one row per cycle, outputs checked after inputs settle.
    typedef struct {
        logic        r;
        logic [2:0]  rq, lk, w;
        logic [23:0] a, d;
        logic [2:0]  g;
        logic        wr;
        logic [2:0]  rv;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] lk,
                                input logic [2:0] w, input logic [23:0] a, input logic [23:0] d,
                                input logic [2:0] g, input logic wr, input logic [2:0] rv);
        vec_t v;
        v.r = r; v.rq = rq; v.lk = lk; v.w = w; v.a = a; v.d = d;
        v.g = g; v.wr = wr; v.rv = rv;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t tbl [NV];

    // Reference model state: owner -1 means nobody holds the lock.
    int         m_owner;
    int         m_ptr;
    logic [2:0] m_rdp;
    logic [7:0] m_rdat;
    logic [7:0] ref_mem [S_DEPTH];

    function automatic int model_pick();
        if (!rst_n) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_cycle();
        int         g;
        logic [2:0] eg;
        logic [7:0] ea, ed;
        logic       ew;
        g  = model_pick();
        eg = (g >= 0) ? 3'(1 << g) : 3'b000;
        ea = (g >= 0) ? addr[g*8 +: 8]  : 8'h00;
        ed = (g >= 0) ? wdata[g*8 +: 8] : 8'h00;
        ew = (g >= 0) ? we[g] : 1'b0;
        chk("rnd_gnt",      gnt,      eg);
        chk("rnd_wren",     ram_wren, ew);
        chk("rnd_ram_addr", ram_addr, ea);
        chk("rnd_ram_data", ram_data, ed);
        chk("rnd_rvalid",   rvalid,   m_rdp);
        if (m_rdp != 3'b000) chk("rnd_rdata", rdata, m_rdat);
        if (!rst_n) begin
            m_ptr   = 0;
            m_owner = -1;
            m_rdp   = 3'b000;
        end else begin
            if (g >= 0 && ew) ref_mem[ea] = ed;
            m_rdp = (g >= 0 && !ew) ? eg : 3'b000;
            if (g >= 0 && !ew) m_rdat = ref_mem[ea];
            if (m_owner >= 0) begin
                if (!lock[m_owner]) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (g >= 0) begin
                if (lock[g]) m_owner = g;
                else         m_ptr   = (g + 1) % N;
            end
        end
    endtask

    initial begin
        int rv_cnt, g_cnt;

        // reset, then all three reading without lock
        tbl[0]  = mk(0, 3'b111, 3'b000, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b000);
        tbl[1]  = mk(1, 3'b111, 3'b000, 3'b000, 24'h0, 24'h0, 3'b001, 0, 3'b000);
        tbl[2]  = mk(1, 3'b111, 3'b000, 3'b000, 24'h0, 24'h0, 3'b010, 0, 3'b001);
        tbl[3]  = mk(1, 3'b111, 3'b000, 3'b000, 24'h0, 24'h0, 3'b100, 0, 3'b010);
        tbl[4]  = mk(1, 3'b111, 3'b000, 3'b000, 24'h0, 24'h0, 3'b001, 0, 3'b100);
        // KSA locked swap of 0x05 and 0x9A while PRGA waits
        tbl[5]  = mk(1, 3'b110, 3'b010, 3'b000, 24'h000500, 24'h0,      3'b010, 0, 3'b001);
        tbl[6]  = mk(1, 3'b110, 3'b010, 3'b000, 24'h009A00, 24'h0,      3'b010, 0, 3'b010);
        tbl[7]  = mk(1, 3'b110, 3'b010, 3'b010, 24'h000500, 24'h009A00, 3'b010, 1, 3'b010);
        tbl[8]  = mk(1, 3'b110, 3'b000, 3'b010, 24'h009A00, 24'h003300, 3'b010, 1, 3'b000);
        tbl[9]  = mk(1, 3'b100, 3'b000, 3'b000, 24'h0, 24'h0, 3'b100, 0, 3'b000);
        // init owns, goes idle with lock held, PRGA waits until the release
        tbl[10] = mk(1, 3'b101, 3'b001, 3'b000, 24'h0, 24'h0, 3'b001, 0, 3'b100);
        tbl[11] = mk(1, 3'b100, 3'b001, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b001);
        tbl[12] = mk(1, 3'b100, 3'b001, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b000);
        tbl[13] = mk(1, 3'b100, 3'b001, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b000);
        tbl[14] = mk(1, 3'b100, 3'b000, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b000);
        tbl[15] = mk(1, 3'b100, 3'b000, 3'b000, 24'h0, 24'h0, 3'b100, 0, 3'b000);
        // reset while KSA owns with a read in flight
        tbl[16] = mk(1, 3'b010, 3'b010, 3'b000, 24'h0, 24'h0, 3'b010, 0, 3'b100);
        tbl[17] = mk(1, 3'b010, 3'b010, 3'b000, 24'h0, 24'h0, 3'b010, 0, 3'b010);
        tbl[18] = mk(0, 3'b010, 3'b010, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b010);
        tbl[19] = mk(1, 3'b110, 3'b000, 3'b000, 24'h0, 24'h0, 3'b010, 0, 3'b000);
        tbl[20] = mk(1, 3'b100, 3'b000, 3'b000, 24'h0, 24'h0, 3'b100, 0, 3'b010);
        tbl[21] = mk(1, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0, 3'b000, 0, 3'b100);

        drive(0, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].r, tbl[i].rq, tbl[i].lk, tbl[i].w, tbl[i].a, tbl[i].d);
            #1;
            chk($sformatf("vec%0d_gnt", i),    gnt,      tbl[i].g);
            chk($sformatf("vec%0d_wren", i),   ram_wren, tbl[i].wr);
            chk($sformatf("vec%0d_rvalid", i), rvalid,   tbl[i].rv);
        end

        // write 0x10 = 0xAB then read it back on the next cycle
        @(negedge clk);
        drive(1, 3'b001, 3'b000, 3'b001, 24'h000010, 24'h0000AB);
        #1;
        chk("wr_gnt", gnt, 3'b001);
        chk("wr_wren", ram_wren, 1'b1);
        chk("wr_addr", ram_addr, 8'h10);
        chk("wr_data", ram_data, 8'hAB);
        @(negedge clk);
        drive(1, 3'b001, 3'b000, 3'b000, 24'h000010, 24'h0);
        #1;
        chk("rd_gnt", gnt, 3'b001);
        chk("rd_after_wr_rvalid", rvalid, 3'b000);
        @(negedge clk);
        drive(1, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        #1;
        chk("raw_rvalid", rvalid, 3'b001);
        chk("raw_rdata", rdata, 8'hAB);

        // PRGA sweeps the whole address space back-to-back, wrapping to 0x00
        rv_cnt = 0;
        g_cnt  = 0;
        for (int i = 0; i <= S_DEPTH; i++) begin
            logic [7:0] a8;
            a8 = 8'(i);
            @(negedge clk);
            drive(1, 3'b100, 3'b000, 3'b000, {a8, 16'h0}, 24'h0);
            #1;
            if (gnt == 3'b100) g_cnt++;
            if (i > 0 && rvalid == 3'b100) rv_cnt++;
            chk($sformatf("sweep%0d_addr", i), ram_addr, a8);
        end
        @(negedge clk);
        drive(1, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        #1;
        if (rvalid == 3'b100) rv_cnt++;
        chk("sweep_gnt_count", g_cnt, S_DEPTH + 1);
        chk("sweep_rvalid_count", rv_cnt, S_DEPTH + 1);
        chk("sweep_idle_addr", ram_addr, 8'h00);

        // randomized traffic against the reference model
        @(negedge clk);
        drive(0, 3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
        @(negedge clk);
        m_ptr   = 0;
        m_owner = -1;
        m_rdp   = 3'b000;
        m_rdat  = 8'h00;
        for (int i = 0; i < S_DEPTH; i++) ref_mem[i] = mem[i];
        for (int c = 0; c < 3000; c++) begin
            logic       r;
            logic [2:0] lk;
            if (c > 0) @(negedge clk);
            r  = ($urandom_range(63) != 0);
            lk = {($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            drive(r, 3'($urandom), lk, 3'($urandom), 24'($urandom), 24'($urandom));
            #1;
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
